pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered next-PC generator; successor to the combinational branch/jump target selector.
- Owns the fetch PC register and computes branch, jump-immediate and jump-register targets. Supports a parametrised branch-delay-slot count (0 or 1), fetch stalls, a one-entry pending-redirect buffer, a flush strobe and a redirect counter.
- Sits between execute (redirect source) and the instruction-fetch stage (PC consumer).

Parameters:
- PC_W, 32: PC and target width.
- IMM_W, 26: jump-immediate field width; must satisfy IMM_W+2 < PC_W.
- RESET_PC, 32'h0040_0000: PC value loaded on reset.
- DELAY_SLOTS, 1: 0 = redirect applied on the next advance; 1 = one sequential delay-slot fetch first.
- CNT_W, 16: redirect counter width.

Ports:
- w_clk  in  1  single clock, rising edge.
- w_rst_n  in  1  asynchronous, active-low reset.
- w_stall  in  1  fetch stall; PC holds while 1.
- w_branch_op  in  1  execute holds a conditional branch.
- w_success  in  1  branch condition true.
- w_jump_op  in  1  execute holds a jump.
- w_imm_op  in  1  jump is immediate (1) or register (0).
- w_br_pc_in  in  PC_W  PC of the redirecting instruction.
- w_alu_imm  in  PC_W  sign-extended, pre-shifted branch offset.
- w_br_imm  in  IMM_W  jump-immediate field.
- w_reg_pc  in  PC_W  jump-register target.
- w_pc_out  out  PC_W  current fetch PC.
- w_pc_valid  out  1  PC is valid for fetch.
- w_flush  out  1  1-cycle pulse: PC just loaded a redirect target.
- w_redirect_drop  out  1  1-cycle pulse: redirect discarded because the buffer was full.
- w_misalign  out  1  1-cycle pulse: target had nonzero bits [1:0].
- w_redirect_cnt  out  CNT_W  saturating count of applied redirects.

Behaviour:
Reset (async, w_rst_n=0):
- w_pc_out=RESET_PC, w_pc_valid=0, all pulses 0, w_redirect_cnt=0, state RUN, pending buffer empty.
- w_pc_valid rises at the first clock edge after reset deassertion.
- Reset mid-operation discards any pending redirect.

Redirect request (cycle t, sampled at its closing edge):
- req = (w_branch_op & w_success) | w_jump_op.
- Target priority: taken branch > jump-imm > jump-reg.
  - Taken branch: target = w_br_pc_in + 4 + w_alu_imm, modulo 2^PC_W.
  - Jump-imm: target = {(w_br_pc_in+4)[PC_W-1:IMM_W+2], w_br_imm, 2'b00}.
  - Jump-reg: target = w_reg_pc.
- Misaligned target (bits [1:0] nonzero): bits [1:0] are cleared before capture; w_misalign pulses in the cycle after capture.

Advance:
- Advance = edge with w_stall=0 and w_pc_valid=1.
- Sequential next = w_pc_out+4, wrapping at 2^PC_W.

FSM (RUN, ARMED, FIRE):
- RUN
  - req with DELAY_SLOTS=0 and advancing: PC=target immediately; w_flush and counter increment next cycle; stay RUN.
  - req with DELAY_SLOTS=0 while stalled: capture target, go to FIRE.
  - req with DELAY_SLOTS=1: capture target, go to ARMED. If advancing, PC=PC+4 on that edge (delay-slot fetch).
- ARMED: on the next advance, PC=PC+4 (delay slot), go to FIRE. Holds through stalls.
- FIRE: on the next advance, PC=captured target, w_flush pulses, counter increments (saturating at all-ones), go to RUN. Holds through stalls.
- ARMED exception: if the RUN-state capture edge also advanced, the slot is already fetched; ARMED then goes straight to FIRE behaviour, and the next advance loads the target.
- req while state != RUN: request ignored (older redirect wins), w_redirect_drop pulses next cycle, captured target unchanged.
- Stall asserted in the same cycle as req: capture still occurs; PC unchanged.
- w_flush, w_redirect_drop and w_misalign are registered pulses, exactly 1 cycle wide.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {RUN, ARMED, FIRE}.
  - PC increment constant 4.
  - Default reset vector.
- One sub-module, pc_target_calc: the combinational target/priority/alignment logic, reusable by the decode-stage predictor.
- FSM, PC register, pending buffer and counter live in pc_sequencer.

Test Plan:
- Reset release, no stall, no req → w_pc_out sequence 0x00400000, 0x00400004, 0x00400008; w_pc_valid=1 from the first edge after release.
- DELAY_SLOTS=1: taken branch at PC 0x00400010, w_br_pc_in=0x00400010, w_alu_imm=0x20 → next PCs 0x00400014 (slot), then 0x00400034; w_flush high the cycle PC=0x00400034; w_redirect_cnt=1.
- DELAY_SLOTS=0: jump-imm with w_br_pc_in=0x00400020, w_br_imm=0x0100040 → next PC 0x00400100; jump-reg with w_reg_pc=0x00400203 → PC 0x00400200 and w_misalign pulses.
- Redirect during 3-cycle stall: PC held through the stall, target applied on the correct post-stall advance; a second req while ARMED → w_redirect_drop pulse, first target still taken.
- Branch op with w_success=0 plus simultaneous jump-reg → jump-reg target used; branch and jump both valid with w_success=1 → branch target used.
- Async reset asserted while in FIRE → w_pc_out=RESET_PC immediately, no w_flush; counter at all-ones plus one more redirect stays at all-ones.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer and its target logic.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } seq_state_e;

    localparam int unsigned PC_INC = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target selection: taken branch > jump-imm > jump-reg,
// with the low two target bits forced to zero and flagged when they were set.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IMM_W = 26
) (
    input  logic              i_branch_op,
    input  logic              i_success,
    input  logic              i_jump_op,
    input  logic              i_imm_op,
    input  logic [PC_W-1:0]   i_br_pc_in,
    input  logic [PC_W-1:0]   i_alu_imm,
    input  logic [IMM_W-1:0]  i_br_imm,
    input  logic [PC_W-1:0]   i_reg_pc,
    output logic              o_req_c,
    output logic [PC_W-1:0]   o_target_c,
    output logic              o_misalign_c
);

    logic            w_taken;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_raw;

    assign w_taken  = i_branch_op & i_success;
    assign w_seq_pc = i_br_pc_in + PC_W'(PC_INC);

    always_comb begin
        w_raw = i_reg_pc;
        if (w_taken) begin
            w_raw = w_seq_pc + i_alu_imm;
        end else if (i_jump_op && i_imm_op) begin
            w_raw = {w_seq_pc[PC_W-1:IMM_W+2], i_br_imm, 2'b00};
        end
    end

    assign o_req_c      = w_taken | i_jump_op;
    assign o_misalign_c = o_req_c & (|w_raw[1:0]);
    assign o_target_c   = {w_raw[PC_W-1:2], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-PC generator with optional branch delay slot, stall hold,
// one-entry pending redirect and a saturating applied-redirect counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     IMM_W       = 26,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEFAULT_RESET_PC),
    parameter int unsigned     DELAY_SLOTS = 1,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_stall,
    input  logic              w_branch_op,
    input  logic              w_success,
    input  logic              w_jump_op,
    input  logic              w_imm_op,
    input  logic [PC_W-1:0]   w_br_pc_in,
    input  logic [PC_W-1:0]   w_alu_imm,
    input  logic [IMM_W-1:0]  w_br_imm,
    input  logic [PC_W-1:0]   w_reg_pc,
    output logic [PC_W-1:0]   w_pc_out,
    output logic              w_pc_valid,
    output logic              w_flush,
    output logic              w_redirect_drop,
    output logic              w_misalign,
    output logic [CNT_W-1:0]  w_redirect_cnt
);

    seq_state_e       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_target;
    logic             r_slot_done;
    logic             r_pc_valid;
    logic             r_flush;
    logic             r_drop;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req;
    logic [PC_W-1:0]  w_target;
    logic             w_mis;
    logic             w_adv;
    logic [PC_W-1:0]  w_pc_seq;
    logic [CNT_W-1:0] w_cnt_next;

    pc_target_calc #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_calc (
        .i_branch_op  (w_branch_op),
        .i_success    (w_success),
        .i_jump_op    (w_jump_op),
        .i_imm_op     (w_imm_op),
        .i_br_pc_in   (w_br_pc_in),
        .i_alu_imm    (w_alu_imm),
        .i_br_imm     (w_br_imm),
        .i_reg_pc     (w_reg_pc),
        .o_req_c      (w_req),
        .o_target_c   (w_target),
        .o_misalign_c (w_mis)
    );

    assign w_adv      = ~w_stall & r_pc_valid;
    assign w_pc_seq   = r_pc + PC_W'(PC_INC);
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    // Redirect FSM; r_slot_done marks that the delay slot was fetched on the capture edge.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_target    <= '0;
            r_slot_done <= 1'b0;
            r_pc_valid  <= 1'b0;
            r_flush     <= 1'b0;
            r_drop      <= 1'b0;
            r_misalign  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pc_valid <= 1'b1;
            r_flush    <= 1'b0;
            r_drop     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_req) begin
                        r_misalign <= w_mis;
                        if (DELAY_SLOTS == 0) begin
                            if (w_adv) begin
                                r_pc    <= w_target;
                                r_flush <= 1'b1;
                                r_cnt   <= w_cnt_next;
                            end else begin
                                r_target <= w_target;
                                r_state  <= ST_FIRE;
                            end
                        end else begin
                            r_target    <= w_target;
                            r_slot_done <= w_adv;
                            r_state     <= ST_ARMED;
                            if (w_adv) begin
                                r_pc <= w_pc_seq;
                            end
                        end
                    end else if (w_adv) begin
                        r_pc <= w_pc_seq;
                    end
                end
                ST_ARMED: begin
                    r_drop <= w_req;
                    if (w_adv) begin
                        if (r_slot_done) begin
                            r_pc    <= r_target;
                            r_flush <= 1'b1;
                            r_cnt   <= w_cnt_next;
                            r_state <= ST_RUN;
                        end else begin
                            r_pc    <= w_pc_seq;
                            r_state <= ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    r_drop <= w_req;
                    if (w_adv) begin
                        r_pc    <= r_target;
                        r_flush <= 1'b1;
                        r_cnt   <= w_cnt_next;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign w_pc_out        = r_pc;
    assign w_pc_valid      = r_pc_valid;
    assign w_flush         = r_flush;
    assign w_redirect_drop = r_drop;
    assign w_misalign      = r_misalign;
    assign w_redirect_cnt  = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: a zero-delay-slot instance driven from a vector table and
// a one-delay-slot instance (3-bit counter) driven by hand-written sequences.
module tb_pc_sequencer;

    typedef struct {
        logic        stall;
        logic        br;
        logic        succ;
        logic        jmp;
        logic        imm;
        logic [31:0] br_pc;
        logic [31:0] alu;
        logic [25:0] brimm;
        logic [31:0] reg_pc;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_mis;
        logic        exp_drop;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic        drop;
    } exp_t;

    logic        clk;
    logic        rst_n0, rst_n1;
    logic        stall, branch_op, success, jump_op, imm_op;
    logic [31:0] br_pc_in, alu_imm, reg_pc;
    logic [25:0] br_imm;

    logic [31:0] pc0, pc1;
    logic        valid0, valid1, flush0, flush1, drop0, drop1, mis0, mis1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;

    int unsigned n_pass;
    int unsigned n_total;
    exp_t        sb_q[$];

    pc_sequencer #(.DELAY_SLOTS(0), .CNT_W(16)) u_ds0 (
        .w_clk(clk), .w_rst_n(rst_n0), .w_stall(stall), .w_branch_op(branch_op),
        .w_success(success), .w_jump_op(jump_op), .w_imm_op(imm_op),
        .w_br_pc_in(br_pc_in), .w_alu_imm(alu_imm), .w_br_imm(br_imm), .w_reg_pc(reg_pc),
        .w_pc_out(pc0), .w_pc_valid(valid0), .w_flush(flush0),
        .w_redirect_drop(drop0), .w_misalign(mis0), .w_redirect_cnt(cnt0)
    );

    pc_sequencer #(.DELAY_SLOTS(1), .CNT_W(3)) u_ds1 (
        .w_clk(clk), .w_rst_n(rst_n1), .w_stall(stall), .w_branch_op(branch_op),
        .w_success(success), .w_jump_op(jump_op), .w_imm_op(imm_op),
        .w_br_pc_in(br_pc_in), .w_alu_imm(alu_imm), .w_br_imm(br_imm), .w_reg_pc(reg_pc),
        .w_pc_out(pc1), .w_pc_valid(valid1), .w_flush(flush1),
        .w_redirect_drop(drop1), .w_misalign(mis1), .w_redirect_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mkv(input logic s, input logic b, input logic sc, input logic j,
                                 input logic im, input logic [31:0] bp, input logic [31:0] al,
                                 input logic [25:0] bi, input logic [31:0] rp, input logic [31:0] ep,
                                 input logic ef, input logic em, input logic ed);
        vec_t v;
        v.stall = s; v.br = b; v.succ = sc; v.jmp = j; v.imm = im;
        v.br_pc = bp; v.alu = al; v.brimm = bi; v.reg_pc = rp;
        v.exp_pc = ep; v.exp_flush = ef; v.exp_mis = em; v.exp_drop = ed;
        return v;
    endfunction

    function automatic vec_t nr(input logic s, input logic [31:0] ep, input logic ef, input logic ed);
        return mkv(s, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, ep, ef, 1'b0, ed);
    endfunction

    function automatic vec_t jr(input logic s, input logic [31:0] rp, input logic [31:0] ep,
                                input logic ef, input logic em, input logic ed);
        return mkv(s, 0, 0, 1, 0, 32'h0, 32'h0, 26'h0, rp, ep, ef, em, ed);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic apply(input vec_t v, input bit sel, input string tag);
        exp_t e;
        stall = v.stall; branch_op = v.br; success = v.succ; jump_op = v.jmp; imm_op = v.imm;
        br_pc_in = v.br_pc; alu_imm = v.alu; br_imm = v.brimm; reg_pc = v.reg_pc;
        e.pc = v.exp_pc; e.flush = v.exp_flush; e.mis = v.exp_mis; e.drop = v.exp_drop;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (sel) begin
            chk({tag, " pc"},    pc1,    e.pc);
            chk({tag, " valid"}, 32'(valid1), 32'd1);
            chk({tag, " flush"}, 32'(flush1), 32'(e.flush));
            chk({tag, " mis"},   32'(mis1),   32'(e.mis));
            chk({tag, " drop"},  32'(drop1),  32'(e.drop));
        end else begin
            chk({tag, " pc"},    pc0,    e.pc);
            chk({tag, " valid"}, 32'(valid0), 32'd1);
            chk({tag, " flush"}, 32'(flush0), 32'(e.flush));
            chk({tag, " mis"},   32'(mis0),   32'(e.mis));
            chk({tag, " drop"},  32'(drop0),  32'(e.drop));
        end
    endtask

    initial begin
        vec_t        tbl[17];
        logic [31:0] p;
        n_pass = 0;
        n_total = 0;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        stall = 0; branch_op = 0; success = 0; jump_op = 0; imm_op = 0;
        br_pc_in = '0; alu_imm = '0; br_imm = '0; reg_pc = '0;

        tbl[0]  = nr(0, 32'h0040_0000, 0, 0);
        tbl[1]  = nr(0, 32'h0040_0004, 0, 0);
        tbl[2]  = nr(0, 32'h0040_0008, 0, 0);
        tbl[3]  = mkv(0, 0, 0, 1, 1, 32'h0040_0020, 32'h0, 26'h010_0040, 32'h0, 32'h0040_0100, 1, 0, 0);
        tbl[4]  = nr(0, 32'h0040_0104, 0, 0);
        tbl[5]  = jr(0, 32'h0040_0203, 32'h0040_0200, 1, 1, 0);
        tbl[6]  = nr(0, 32'h0040_0204, 0, 0);
        tbl[7]  = mkv(0, 1, 0, 1, 0, 32'h0040_0000, 32'h40, 26'h0, 32'h0040_0300, 32'h0040_0300, 1, 0, 0);
        tbl[8]  = mkv(0, 1, 1, 1, 1, 32'h0040_0300, 32'hFFFF_FFF0, 26'h3FF_FFFF, 32'h0040_0700, 32'h0040_02F4, 1, 0, 0);
        tbl[9]  = jr(1, 32'h0040_0500, 32'h0040_02F4, 0, 0, 0);
        tbl[10] = jr(1, 32'h0040_0601, 32'h0040_02F4, 0, 0, 1);
        tbl[11] = nr(1, 32'h0040_02F4, 0, 0);
        tbl[12] = nr(0, 32'h0040_0500, 1, 0);
        tbl[13] = nr(0, 32'h0040_0504, 0, 0);
        tbl[14] = mkv(0, 1, 1, 0, 0, 32'hFFFF_FFF0, 32'h8, 26'h0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0);
        tbl[15] = nr(0, 32'h0000_0000, 0, 0);
        tbl[16] = mkv(0, 0, 0, 1, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFF, 32'h0, 32'hFFFF_FFFC, 1, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst ds0 pc",    pc0, 32'h0040_0000);
        chk("rst ds0 valid", 32'(valid0), 32'd0);
        chk("rst ds0 pulses", 32'({flush0, drop0, mis0}), 32'd0);
        chk("rst ds0 cnt",   32'(cnt0), 32'd0);
        chk("rst ds1 pc",    pc1, 32'h0040_0000);
        chk("rst ds1 valid", 32'(valid1), 32'd0);

        rst_n0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], 1'b0, $sformatf("ds0 v%0d", i));
        end
        chk("ds0 cnt", 32'(cnt0), 32'd7);

        rst_n1 = 1'b1;
        apply(nr(0, 32'h0040_0000, 0, 0), 1'b1, "ds1 seq0");
        apply(nr(0, 32'h0040_0004, 0, 0), 1'b1, "ds1 seq1");
        apply(nr(0, 32'h0040_0008, 0, 0), 1'b1, "ds1 seq2");
        apply(nr(0, 32'h0040_000C, 0, 0), 1'b1, "ds1 seq3");
        apply(nr(0, 32'h0040_0010, 0, 0), 1'b1, "ds1 seq4");
        apply(mkv(0, 1, 1, 0, 0, 32'h0040_0010, 32'h20, 26'h0, 32'h0, 32'h0040_0014, 0, 0, 0), 1'b1, "ds1 br slot");
        apply(nr(0, 32'h0040_0034, 1, 0), 1'b1, "ds1 br tgt");
        chk("ds1 cnt1", 32'(cnt1), 32'd1);

        apply(jr(1, 32'h0040_0800, 32'h0040_0034, 0, 0, 0), 1'b1, "ds1 stall req");
        apply(jr(1, 32'h0040_0900, 32'h0040_0034, 0, 0, 1), 1'b1, "ds1 armed drop");
        apply(nr(1, 32'h0040_0034, 0, 0), 1'b1, "ds1 stall3");
        apply(nr(0, 32'h0040_0038, 0, 0), 1'b1, "ds1 post slot");
        apply(nr(0, 32'h0040_0800, 1, 0), 1'b1, "ds1 post tgt");
        chk("ds1 cnt2", 32'(cnt1), 32'd2);

        p = 32'h0040_0800;
        for (int i = 0; i < 6; i++) begin
            apply(jr(0, 32'h0040_1000, p + 32'd4, 0, 0, 0), 1'b1, $sformatf("ds1 sat%0d slot", i));
            apply(nr(0, 32'h0040_1000, 1, 0), 1'b1, $sformatf("ds1 sat%0d tgt", i));
            p = 32'h0040_1000;
            chk($sformatf("ds1 sat%0d cnt", i), 32'(cnt1), (i >= 4) ? 32'd7 : 32'(3 + i));
        end

        apply(jr(1, 32'h0040_2000, 32'h0040_1000, 0, 0, 0), 1'b1, "ds1 fire arm");
        apply(nr(0, 32'h0040_1004, 0, 0), 1'b1, "ds1 fire slot");
        apply(nr(1, 32'h0040_1004, 0, 0), 1'b1, "ds1 fire hold");
        rst_n1 = 1'b0;
        #1;
        chk("ds1 async rst pc",    pc1, 32'h0040_0000);
        chk("ds1 async rst valid", 32'(valid1), 32'd0);
        chk("ds1 async rst flush", 32'(flush1), 32'd0);
        chk("ds1 async rst cnt",   32'(cnt1), 32'd0);
        #1;
        rst_n1 = 1'b1;
        apply(nr(0, 32'h0040_0000, 0, 0), 1'b1, "ds1 post rst0");
        apply(nr(0, 32'h0040_0004, 0, 0), 1'b1, "ds1 post rst1");
        apply(nr(0, 32'h0040_0008, 0, 0), 1'b1, "ds1 post rst2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
